// File: rtl/fpu_alu_exec_element.sv
// Single-precision FPU ALU execution element. An operation is launched when
// reset falls. Simple ops finish in one cycle, ADD/SUB/MUL/CVT in two, and
// DIV/SQRT run a restoring one-bit-per-cycle loop for 25 iterations.
module fpu_alu_exec_element (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  inst_num,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  output logic        completed,
  output logic [31:0] out
);

  localparam logic [5:0]  OP_ABS   = 6'd54;
  localparam logic [5:0]  OP_NEG   = 6'd55;
  localparam logic [5:0]  OP_ADD   = 6'd56;
  localparam logic [5:0]  OP_SUB   = 6'd57;
  localparam logic [5:0]  OP_MUL   = 6'd58;
  localparam logic [5:0]  OP_DIV   = 6'd59;
  localparam logic [5:0]  OP_CVTSW = 6'd60;
  localparam logic [5:0]  OP_CVTWS = 6'd61;
  localparam logic [5:0]  OP_MOV   = 6'd62;
  localparam logic [5:0]  OP_SQRT  = 6'd63;
  localparam logic [31:0] QNAN     = 32'h7fc0_0000;
  localparam logic [4:0]  LAST_IT  = 5'd24;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic        completed_q, completed_d;
  logic [31:0] out_q, out_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] fs_q, fs_d, ft_q, ft_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [27:0] rem_q, rem_d;
  logic [24:0] quo_q, quo_d;
  logic [49:0] rad_q, rad_d;

  // Leading-zero count of a 32-bit word (32 when the word is zero).
  function automatic logic [5:0] clz32(input logic [31:0] v);
    clz32 = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) clz32 = 6'(31 - i);
    end
  endfunction

  // Round-to-nearest-even on a normalized 24-bit mantissa, then pack with
  // overflow to infinity and underflow flush to signed zero.
  function automatic logic [31:0] round_pack(input logic sgn, input logic signed [9:0] exp_in,
                                             input logic [23:0] mant, input logic grd,
                                             input logic stk);
    logic [24:0]       m_r;
    logic signed [9:0] e_r;
    logic [22:0]       frac;
    m_r = {1'b0, mant} + {24'd0, grd & (stk | mant[0])};
    if (m_r[24]) begin
      e_r  = exp_in + 10'sd1;
      frac = m_r[23:1];
    end else begin
      e_r  = exp_in;
      frac = m_r[22:0];
    end
    if (e_r >= 10'sd255)    round_pack = {sgn, 8'hff, 23'd0};
    else if (e_r <= 10'sd0) round_pack = {sgn, 31'd0};
    else                    round_pack = {sgn, e_r[7:0], frac};
  endfunction

  // Float add: align the smaller operand with guard/round/sticky, add or
  // subtract magnitudes, renormalize by leading-zero count.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [30:0]       mag_a, mag_b;
    logic [31:0]       big, sml;
    logic [7:0]        d;
    logic [26:0]       bx, sx, sh, mask, nrm;
    logic [27:0]       sum;
    logic [5:0]        lz;
    logic signed [9:0] e;
    mag_a = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
    mag_b = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
    if (mag_a >= mag_b) begin
      big = {a[31], mag_a};
      sml = {b[31], mag_b};
    end else begin
      big = {b[31], mag_b};
      sml = {a[31], mag_a};
    end
    d    = big[30:23] - sml[30:23];
    bx   = {(big[30:23] != 8'd0), big[22:0], 3'b000};
    sx   = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
    mask = ~({27{1'b1}} << d);
    if (d > 8'd26) sh = {26'd0, |sx};
    else           sh = (sx >> d) | {26'd0, |(sx & mask)};
    if (big[31] == sml[31]) sum = {1'b0, bx} + {1'b0, sh};
    else                    sum = {1'b0, bx} - {1'b0, sh};
    e  = $signed({2'b00, big[30:23]});
    lz = 6'd0;
    if (sum[27]) begin
      nrm = sum[27:1] | {26'd0, sum[0]};
      e   = e + 10'sd1;
    end else begin
      lz  = clz32({sum[26:0], 5'd0});
      nrm = sum[26:0] << lz;
      e   = e - $signed({4'd0, lz});
    end
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) fp_add = {big[31], 8'hff, 23'd0};
    else if (sum == 28'd0)                      fp_add = {a[31] & b[31], 31'd0};
    else fp_add = round_pack(big[31], e, nrm[26:3], nrm[2], |nrm[1:0]);
  endfunction

  // Float multiply: 24x24 mantissa product, one-bit normalize, round.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [47:0]       p;
    logic signed [9:0] e;
    sgn = a[31] ^ b[31];
    p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (a[30:23] == 8'hff || b[30:23] == 8'hff)      fp_mul = {sgn, 8'hff, 23'd0};
    else if (a[30:23] == 8'd0 || b[30:23] == 8'd0)   fp_mul = {sgn, 31'd0};
    else if (p[47]) fp_mul = round_pack(sgn, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    else            fp_mul = round_pack(sgn, e, p[46:23], p[22], |p[21:0]);
  endfunction

  // Signed int32 to float, round to nearest even.
  function automatic logic [31:0] cvt_sw(input logic [31:0] x);
    logic [31:0]       mag, n;
    logic [5:0]        lz;
    logic signed [9:0] e;
    mag = x[31] ? (~x + 32'd1) : x;
    lz  = clz32(mag);
    n   = mag << lz;
    e   = 10'sd158 - $signed({4'd0, lz});
    if (x == 32'd0) cvt_sw = 32'd0;
    else            cvt_sw = round_pack(x[31], e, n[31:8], n[7], |n[6:0]);
  endfunction

  // Float to signed int32, round to nearest even, saturating.
  function automatic logic [31:0] cvt_ws(input logic [31:0] a);
    logic [23:0] m;
    logic [55:0] t;
    logic [31:0] mag;
    logic [7:0]  sh;
    m   = {1'b1, a[22:0]};
    t   = 56'd0;
    sh  = 8'd0;
    mag = 32'd0;
    if (a[30:23] < 8'd126) begin
      mag = 32'd0;
    end else if (a[30:23] >= 8'd150) begin
      mag = {8'd0, m} << (a[30:23] - 8'd150);
    end else begin
      sh  = 8'd150 - a[30:23];
      t   = {m, 32'd0} >> sh;
      mag = {8'd0, t[55:32]} + {31'd0, t[31] & ((|t[30:0]) | t[32])};
    end
    if (a[30:23] >= 8'd158) cvt_ws = a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    else                    cvt_ws = a[31] ? (~mag + 32'd1) : mag;
  endfunction

  logic [23:0]       man_a, man_b;
  logic              div_lt;
  logic [27:0]       div_rem0;
  logic [49:0]       sq_rad0;
  logic [27:0]       div_rem_n, sq_rem_t, sq_trial, sq_rem_n, rem_n;
  logic [24:0]       div_quo_n, sq_quo_n, quo_n;
  logic signed [9:0] div_exp, sq_exp;
  logic [9:0]        sq_sum;
  logic              sgn_md;
  logic [31:0]       simple_res, arith_res, iter_res;

  // Operand unpacking plus one restoring step for divide and square root.
  always_comb begin
    man_a    = {1'b1, fs_q[22:0]};
    man_b    = {1'b1, ft_q[22:0]};
    div_lt   = man_a < man_b;
    div_rem0 = div_lt ? {3'd0, man_a, 1'b0} : {4'd0, man_a};
    sq_rad0  = fs_q[23] ? {1'b0, man_a, 25'd0} : {man_a, 26'd0};
    if (rem_q >= {4'd0, man_b}) begin
      div_quo_n = {quo_q[23:0], 1'b1};
      div_rem_n = (rem_q - {4'd0, man_b}) << 1;
    end else begin
      div_quo_n = {quo_q[23:0], 1'b0};
      div_rem_n = rem_q << 1;
    end
    sq_rem_t = {rem_q[25:0], rad_q[49:48]};
    sq_trial = {1'b0, quo_q, 2'b01};
    if (sq_rem_t >= sq_trial) begin
      sq_quo_n = {quo_q[23:0], 1'b1};
      sq_rem_n = sq_rem_t - sq_trial;
    end else begin
      sq_quo_n = {quo_q[23:0], 1'b0};
      sq_rem_n = sq_rem_t;
    end
    quo_n = (op_q == OP_SQRT) ? sq_quo_n : div_quo_n;
    rem_n = (op_q == OP_SQRT) ? sq_rem_n : div_rem_n;
  end

  // Result selection for every opcode class, including special operands.
  always_comb begin
    sgn_md  = fs_q[31] ^ ft_q[31];
    div_exp = $signed({2'b00, fs_q[30:23]}) - $signed({2'b00, ft_q[30:23]})
              + 10'sd127 - $signed({9'd0, div_lt});
    sq_sum  = {2'b00, fs_q[30:23]} + 10'd127;
    sq_exp  = $signed({1'b0, sq_sum[9:1]});
    case (op_q)
      OP_ABS:  simple_res = {1'b0, fs_q[30:0]};
      OP_NEG:  simple_res = {~fs_q[31], fs_q[30:0]};
      OP_MOV:  simple_res = fs_q;
      default: simple_res = 32'd0;
    endcase
    case (op_q)
      OP_ADD:   arith_res = fp_add(fs_q, ft_q);
      OP_SUB:   arith_res = fp_add(fs_q, {~ft_q[31], ft_q[30:0]});
      OP_MUL:   arith_res = fp_mul(fs_q, ft_q);
      OP_CVTSW: arith_res = cvt_sw(fs_q);
      default:  arith_res = cvt_ws(fs_q);
    endcase
    if (op_q == OP_SQRT) begin
      if (fs_q[30:23] == 8'd0)        iter_res = {fs_q[31], 31'd0};
      else if (fs_q[31])              iter_res = QNAN;
      else if (fs_q[30:23] == 8'hff)  iter_res = 32'h7f80_0000;
      else iter_res = round_pack(1'b0, sq_exp, quo_n[24:1], quo_n[0], rem_n != 28'd0);
    end else begin
      if (fs_q[30:23] == 8'd0 && ft_q[30:23] == 8'd0)        iter_res = QNAN;
      else if (ft_q[30:23] == 8'd0)                          iter_res = {sgn_md, 8'hff, 23'd0};
      else if (fs_q[30:23] == 8'hff || ft_q[30:23] == 8'hff) iter_res = {sgn_md, 8'hff, 23'd0};
      else if (fs_q[30:23] == 8'd0)                          iter_res = {sgn_md, 31'd0};
      else iter_res = round_pack(sgn_md, div_exp, quo_n[24:1], quo_n[0], rem_n != 28'd0);
    end
  end

  // Next-state logic of the IDLE -> RUN -> DONE sequencer.
  always_comb begin
    state_d     = state_q;
    completed_d = completed_q;
    out_d       = out_q;
    op_d        = op_q;
    fs_d        = fs_q;
    ft_d        = ft_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    rad_d       = rad_q;
    if (reset) begin
      op_d = inst_num;
      fs_d = fs;
      ft_d = ft;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = 5'd0;
          quo_d = 25'd0;
          if (op_q < OP_ADD || op_q == OP_MOV) begin
            out_d       = simple_res;
            completed_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            rem_d   = (op_q == OP_DIV) ? div_rem0 : 28'd0;
            rad_d   = sq_rad0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (op_q == OP_DIV || op_q == OP_SQRT) begin
            rem_d = rem_n;
            quo_d = quo_n;
            rad_d = {rad_q[47:0], 2'b00};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_IT) begin
              out_d       = iter_res;
              completed_d = 1'b1;
              state_d     = ST_DONE;
            end
          end else begin
            out_d       = arith_res;
            completed_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
        default: state_d = ST_DONE;
      endcase
    end
  end

  // State registers; reset clears only the control state and the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      completed_q <= 1'b0;
      out_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      completed_q <= completed_d;
      out_q       <= out_d;
    end
    op_q  <= op_d;
    fs_q  <= fs_d;
    ft_q  <= ft_d;
    cnt_q <= cnt_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
    rad_q <= rad_d;
  end

  assign completed = completed_q;
  assign out       = out_q;

endmodule

// File: tb/tb_fpu_alu_exec_element.sv
// Directed-vector bench for fpu_alu_exec_element: result, latency, reset
// clearing and post-completion stability for each opcode class.
module tb_fpu_alu_exec_element;

  logic        clk;
  logic        reset;
  logic [5:0]  inst_num;
  logic [31:0] fs;
  logic [31:0] ft;
  logic        completed;
  logic [31:0] out;

  int n_total;
  int n_bad;

  fpu_alu_exec_element dut (
    .clk       (clk),
    .reset     (reset),
    .inst_num  (inst_num),
    .fs        (fs),
    .ft        (ft),
    .completed (completed),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Pulse reset with the operands, then release and scramble the inputs.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int want_lat);
    int lat;
    @(negedge clk);
    reset = 1'b1; inst_num = op; fs = a; ft = b;
    @(posedge clk); #1;
    chk({tag, "_rst_cmp"}, {31'd0, completed}, 32'd0);
    chk({tag, "_rst_out"}, out, 32'd0);
    @(negedge clk);
    reset = 1'b0; inst_num = ~op; fs = ~a; ft = ~b;
    lat = 0;
    while (lat < 40 && !completed) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
    chk({tag, "_out"}, out, want);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_out"}, out, want);
    chk({tag, "_hold_cmp"}, {31'd0, completed}, 32'd1);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1; inst_num = 6'd0; fs = 32'd0; ft = 32'd0;
    repeat (2) @(posedge clk);

    run_op("abs",      6'd54, 32'hffffffff, 32'h0,        32'h7fffffff, 1);
    run_op("neg_pos",  6'd55, 32'h7fffffff, 32'h0,        32'hffffffff, 1);
    run_op("neg_neg",  6'd55, 32'hffffffff, 32'h0,        32'h7fffffff, 1);
    run_op("mov",      6'd62, 32'hf468fa99, 32'h1,        32'hf468fa99, 1);
    run_op("undef",    6'd0,  32'h4048f5c3, 32'h1,        32'h00000000, 1);
    run_op("add",      6'd56, 32'h4048f5c3, 32'h411ffbe7, 32'h41523958, 2);
    run_op("add_neg",  6'd56, 32'h4048f5c3, 32'hc11ffbe7, 32'hc0db7cec, 2);
    run_op("sub",      6'd57, 32'h4048f5c3, 32'h411ffbe7, 32'hc0db7cec, 2);
    run_op("sub_nn",   6'd57, 32'hc048f5c3, 32'hc11ffbe7, 32'h40db7cec, 2);
    run_op("add_canc", 6'd56, 32'h4048f5c3, 32'hc048f5c3, 32'h00000000, 2);
    run_op("mul",      6'd58, 32'h4048f5c3, 32'h411ffbe7, 32'h41fb2cc5, 2);
    run_op("mul_n1",   6'd58, 32'hc048f5c3, 32'h411ffbe7, 32'hc1fb2cc5, 2);
    run_op("mul_n2",   6'd58, 32'hc048f5c3, 32'hc11ffbe7, 32'h41fb2cc5, 2);
    run_op("mul_ovf",  6'd58, 32'h7f000000, 32'h7f000000, 32'h7f800000, 2);
    run_op("div",      6'd59, 32'h4048f5c3, 32'h411ffbe7, 32'h3ea0c8ba, 26);
    run_op("div_n1",   6'd59, 32'h4048f5c3, 32'hc11ffbe7, 32'hbea0c8ba, 26);
    run_op("div_x0",   6'd59, 32'h4048f5c3, 32'h00000000, 32'h7f800000, 26);
    run_op("div_00",   6'd59, 32'h00000000, 32'h00000000, 32'h7fc00000, 26);
    run_op("cvtsw_p",  6'd60, 32'h0012d687, 32'h0,        32'h4996b438, 2);
    run_op("cvtsw_n",  6'd60, 32'hfa1cf588, 32'h0,        32'hccbc614f, 2);
    run_op("cvtsw_mn", 6'd60, 32'h80000000, 32'h0,        32'hcf000000, 2);
    run_op("cvtsw_z",  6'd60, 32'h00000000, 32'h0,        32'h00000000, 2);
    run_op("cvtws",    6'd61, 32'h4996b438, 32'h0,        32'h0012d687, 2);
    run_op("cvtws_sp", 6'd61, 32'h4f000000, 32'h0,        32'h7fffffff, 2);
    run_op("cvtws_sn", 6'd61, 32'hcf800000, 32'h0,        32'h80000000, 2);
    run_op("cvtws_15", 6'd61, 32'h3fc00000, 32'h0,        32'h00000002, 2);
    run_op("cvtws_25", 6'd61, 32'h40200000, 32'h0,        32'h00000002, 2);
    run_op("sqrt16",   6'd63, 32'h41800000, 32'h0,        32'h40800000, 26);
    run_op("sqrt4",    6'd63, 32'h40800000, 32'h0,        32'h40000000, 26);
    run_op("sqrt_nz",  6'd63, 32'h80000000, 32'h0,        32'h80000000, 26);
    run_op("sqrt_neg", 6'd63, 32'hc0800000, 32'h0,        32'h7fc00000, 26);

    // Abort a divide part way through, then run a fresh operation.
    @(negedge clk);
    reset = 1'b1; inst_num = 6'd59; fs = 32'h4048f5c3; ft = 32'h411ffbe7;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, completed}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_cmp", {31'd0, completed}, 32'd0);
    chk("abort_out", out, 32'd0);
    run_op("post_abort_mul", 6'd58, 32'h4048f5c3, 32'h411ffbe7, 32'h41fb2cc5, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
